cdc_rqack_data: RTL

- Parametrised successor of the single-bit request/acknowledge pulse crosser.
- Carries a DATA_WIDTH payload with each request from the wr_clk domain to the rd_clk domain.
- Uses a 2-phase toggle handshake with SYNC_STAGES-deep synchronizers in both directions.
- Adds rd-side valid/ready backpressure and a wr-side completion pulse.
- Used for low-rate control/configuration transfers between OpTiMSoC clock domains.

---
 rtl/cdc_rqack_data.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cdc_rqack_data.sv
// Request/acknowledge clock-domain crosser carrying a DATA_WIDTH payload from wr_clk to rd_clk.
// Optional wr-side drop counter enabled by defining CDC_RQACK_DROPCNT_EN.
`timescale 1ns/1ps
module cdc_rqack_data #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  rd_clk,
`ifdef CDC_RQACK_DROPCNT_EN
  input  logic                  wr_dropcnt_clr,
  output logic [7:0]            wr_dropcnt,
`endif
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready
);

  logic                   req_tgl_q;
  logic                   req_tgl_d;
  logic [DATA_WIDTH-1:0]  hold_data_q;
  logic [DATA_WIDTH-1:0]  hold_data_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_prev_q;
  logic                   ack_sync_s;
  logic                   accept_s;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_sync_s;
  logic                   ack_tgl_q;
  logic                   ack_tgl_d;
  logic                   rd_valid_q;
  logic                   rd_valid_d;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  rd_data_d;

  assign ack_sync_s = ack_sync_q[SYNC_STAGES-1];
  assign req_sync_s = req_sync_q[SYNC_STAGES-1];
  assign wr_busy    = req_tgl_q ^ ack_sync_s;
  assign wr_done    = ack_sync_s ^ ack_prev_q;
  assign accept_s   = wr_req & ~wr_busy;

  // Write side next state: capture payload and flip the request toggle on acceptance
  always_comb begin
    req_tgl_d   = req_tgl_q;
    hold_data_d = hold_data_q;
    if (accept_s) begin
      req_tgl_d   = ~req_tgl_q;
      hold_data_d = wr_data;
    end else begin
      req_tgl_d   = req_tgl_q;
      hold_data_d = hold_data_q;
    end
  end

  // Write side registers and the rd-to-wr acknowledge synchronizer
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      req_tgl_q   <= 1'b0;
      hold_data_q <= '0;
      ack_sync_q  <= '0;
      ack_prev_q  <= 1'b0;
    end else begin
      req_tgl_q   <= req_tgl_d;
      hold_data_q <= hold_data_d;
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
      ack_prev_q  <= ack_sync_s;
    end
  end

  // Read side next state; hold_data is quasi-static while a toggle is pending, so it is sampled directly
  always_comb begin
    ack_tgl_d  = ack_tgl_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_valid_q) begin
      if (rd_ready) begin
        rd_valid_d = 1'b0;
        ack_tgl_d  = req_sync_s;
      end else begin
        rd_valid_d = 1'b1;
        ack_tgl_d  = ack_tgl_q;
      end
    end else if (req_sync_s != ack_tgl_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hold_data_q;
    end else begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

  // Read side registers and the wr-to-rd request synchronizer
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_tgl_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
      ack_tgl_q  <= ack_tgl_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef CDC_RQACK_DROPCNT_EN
  logic [7:0] dropcnt_q;
  logic [7:0] dropcnt_d;

  // Saturating count of requests dropped while busy; clear has priority
  always_comb begin
    dropcnt_d = dropcnt_q;
    if (wr_dropcnt_clr) begin
      dropcnt_d = 8'h00;
    end else if (wr_req && wr_busy && (dropcnt_q != 8'hFF)) begin
      dropcnt_d = dropcnt_q + 8'h01;
    end else begin
      dropcnt_d = dropcnt_q;
    end
  end

  // Drop counter register
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      dropcnt_q <= 8'h00;
    end else begin
      dropcnt_q <= dropcnt_d;
    end
  end

  assign wr_dropcnt = dropcnt_q;
`endif

endmodule
